// File: rtl/muldiv_iter_if.sv
// Request/response bundle for the iterative multiply/divide unit.
//   valid_i/ready_o        : operation request handshake (op_a_i, op_b_i, funct3_i)
//   valid_o/ready_i        : result handshake (result_o)
//   flush_i                : kill the in-flight operation
//   busy_o                 : unit is not idle
// The slave modport is used by the unit; master is the EX-stage side.
interface muldiv_iter_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic [2:0]      funct3_i;
  logic            flush_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  modport slave (
    input  valid_i, op_a_i, op_b_i, funct3_i, flush_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );

  modport master (
    output valid_i, op_a_i, op_b_i, funct3_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit.
//   clk_i  : clock, all state on rising edge
//   rst_ni : synchronous active-low reset
//   bus    : muldiv_iter_if slave (request, result, flush, busy)
// Multiplies by shift-add (MUL_STEP bits/cycle), divides by restoring
// division (1 bit/cycle); divide-by-zero and signed overflow finish at accept.
module muldiv_iter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 4
) (
  input logic          clk_i,
  input logic          rst_ni,
  muldiv_iter_if.slave bus
);
  localparam int unsigned CW      = $clog2(XLEN) + 1;
  localparam int unsigned MUL_CYC = XLEN / MUL_STEP;
  localparam int unsigned SW      = XLEN + MUL_STEP;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_op;
  logic               r_neg;
  logic [CW-1:0]      r_cnt;
  logic [2*XLEN-1:0]  r_acc;
  logic [XLEN-1:0]    r_b;
  logic [XLEN-1:0]    r_result;
  logic               r_valid, r_ready, r_busy;

  // Accept-time decode: operand signs, magnitudes and one-cycle special cases
  logic            w_accept, w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
  logic            w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_special_res;

  assign w_accept   = bus.valid_i && r_ready && !bus.flush_i;
  assign w_is_div   = bus.funct3_i[2];
  assign w_a_signed = bus.funct3_i inside {F_MUL, F_MULH, F_MULHSU, F_DIV, F_REM};
  assign w_b_signed = bus.funct3_i inside {F_MUL, F_MULH, F_DIV, F_REM};
  assign w_sa       = w_a_signed && bus.op_a_i[XLEN-1];
  assign w_sb       = w_b_signed && bus.op_b_i[XLEN-1];
  assign w_mag_a    = w_sa ? XLEN'(-bus.op_a_i) : bus.op_a_i;
  assign w_mag_b    = w_sb ? XLEN'(-bus.op_b_i) : bus.op_b_i;
  assign w_b_zero   = (bus.op_b_i == '0);
  assign w_ovf      = (bus.funct3_i == F_DIV || bus.funct3_i == F_REM) &&
                      (bus.op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.op_b_i);
  assign w_special  = w_is_div && (w_b_zero || w_ovf);

  // funct3[1] distinguishes REM/REMU from DIV/DIVU
  always_comb begin
    w_special_res = '0;
    if (w_b_zero) w_special_res = bus.funct3_i[1] ? bus.op_a_i : '1;
    else          w_special_res = bus.funct3_i[1] ? '0 : bus.op_a_i;
  end

  // Multiply step: add multiplicand * low digit into upper half, shift right
  logic [MUL_STEP-1:0] w_digit;
  logic [SW-1:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_nxt;

  assign w_digit   = r_acc[MUL_STEP-1:0];
  assign w_mul_sum = SW'(r_acc[2*XLEN-1:XLEN]) + SW'(r_b) * SW'(w_digit);
  assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:MUL_STEP]};

  // Divide step: {rem, quo} shifts left; keep the trial difference if no borrow
  logic [XLEN:0]     w_rem_sh, w_diff;
  logic [2*XLEN-1:0] w_div_nxt;

  assign w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_div_nxt = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                  : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

  // Sign fix-up and result selection
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;

  assign w_prod = r_neg ? (2*XLEN)'(-r_acc) : r_acc;
  assign w_quo  = r_neg ? XLEN'(-r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
  assign w_rem  = r_neg ? XLEN'(-r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    if (r_op[2])            w_fix_res = r_op[1] ? w_rem : w_quo;
    else if (r_op == F_MUL) w_fix_res = w_prod[XLEN-1:0];
    else                    w_fix_res = w_prod[2*XLEN-1:XLEN];
  end

  // Next-state logic; flush overrides everything except reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (bus.ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush_i) w_state_nxt = S_IDLE;
  end

  // State and registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == S_DONE);
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Datapath; result register only changes at special accept or in FIX
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op  <= bus.funct3_i;
      r_neg <= (w_is_div && bus.funct3_i[1]) ? w_sa : (w_sa ^ w_sb);
      r_cnt <= w_is_div ? CW'(XLEN - 1) : CW'(MUL_CYC - 1);
      r_acc <= {{XLEN{1'b0}}, w_mag_a};
      r_b   <= w_mag_b;
      if (w_special) r_result <= w_special_res;
    end else if (r_state == S_CALC) begin
      r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
      r_cnt <= r_cnt - CW'(1);
    end else if (r_state == S_FIX && !bus.flush_i) begin
      r_result <= w_fix_res;
    end
  end

  assign bus.ready_o  = r_ready;
  assign bus.valid_o  = r_valid;
  assign bus.busy_o   = r_busy;
  assign bus.result_o = r_result;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed and reference-model checks for muldiv_iter (XLEN=32, MUL_STEP=4).
module tb_muldiv_iter;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  muldiv_iter_if #(.XLEN(32)) bus ();

  muldiv_iter #(.XLEN(32), .MUL_STEP(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference built on 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (f)
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!bus.ready_o && n < 200) begin @(posedge clk); #1; n++; end
    bus.valid_i = 1'b1; bus.funct3_i = f; bus.op_a_i = a; bus.op_b_i = b;
    @(posedge clk); #1;
    // Scramble inputs after accept: the unit must not re-sample them
    bus.valid_i = 1'b0; bus.funct3_i = f ^ 3'b011; bus.op_a_i = ~a; bus.op_b_i = ~b;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.valid_o && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume();
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    start_op(f, a, b);
    wait_valid(lat);
    res = bus.result_o;
    consume();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.flush_i = 1'b0;
    bus.op_a_i = '0; bus.op_b_i = '0; bus.funct3_i = '0;
    repeat (2) @(posedge clk);
    #1;
    total += 4;
    if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
    if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.ready_o); end
    if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    if (bus.result_o !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [2:0]  f[5]   = '{MULH, MUL, MULHSU, MULHU, MUL};
    logic [31:0] a[5]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] b[5]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    logic [31:0] exp[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFEB};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(f[i], a[i], b[i], res, lat);
      total += 2;
      if (res !== exp[i]) begin bad++; $display("FAIL mul_result[%0d] got=%h exp=%h", i, res, exp[i]); end
      if (lat !== 10) begin bad++; $display("FAIL mul_latency[%0d] got=%0d exp=10", i, lat); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f[6]   = '{DIVU, REMU, REM, DIV, DIV, REM};
    logic [31:0] a[6]   = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b[6]   = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] exp[6] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF2, 32'd2};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(f[i], a[i], b[i], res, lat);
      total += 2;
      if (res !== exp[i]) begin bad++; $display("FAIL div_result[%0d] got=%h exp=%h", i, res, exp[i]); end
      if (lat !== 34) begin bad++; $display("FAIL div_latency[%0d] got=%0d exp=34", i, lat); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f[6]   = '{DIV, REM, REM, DIV, DIVU, REMU};
    logic [31:0] a[6]   = '{32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5, 32'd5, 32'h1234_5678};
    logic [31:0] b[6]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] exp[6] = '{32'h8000_0000, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(f[i], a[i], b[i], res, lat);
      total += 2;
      if (res !== exp[i]) begin bad++; $display("FAIL special_result[%0d] got=%h exp=%h", i, res, exp[i]); end
      if (lat !== 1) begin bad++; $display("FAIL special_latency[%0d] got=%0d exp=1", i, lat); end
    end
  endtask

  task automatic test_hold();
    int lat;
    start_op(MUL, 32'd3, 32'd5);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      total += 3;
      if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, bus.valid_o); end
      if (bus.result_o !== 32'd15) begin bad++; $display("FAIL hold_result[%0d] got=%h exp=f", i, bus.result_o); end
      if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL hold_ready[%0d] got=%b exp=0", i, bus.ready_o); end
      @(posedge clk); #1;
    end
    consume();
    total += 2;
    if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL hold_release_valid got=%b exp=0", bus.valid_o); end
    if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL hold_release_ready got=%b exp=1", bus.ready_o); end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat;
    bit seen;
    // Flush during cycle 12 of a DIVU
    start_op(DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    total += 4;
    if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", bus.busy_o); end
    if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", bus.ready_o); end
    if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", bus.valid_o); end
    if (bus.result_o !== 32'd15) begin bad++; $display("FAIL flush_result_kept got=%h exp=f", bus.result_o); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.valid_o) seen = 1'b1;
      @(posedge clk); #1;
    end
    total += 1;
    if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_pulse got=%b exp=0", seen); end
    do_op(DIVU, 32'd1000, 32'd3, res, lat);
    total += 2;
    if (res !== 32'd333) begin bad++; $display("FAIL flush_next_result got=%h exp=14d", res); end
    if (lat !== 34) begin bad++; $display("FAIL flush_next_latency got=%0d exp=34", lat); end

    // Flush and ready together in DONE: flush wins, result register kept
    start_op(MUL, 32'd6, 32'd7);
    wait_valid(lat);
    bus.flush_i = 1'b1; bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.ready_i = 1'b0;
    total += 3;
    if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL flush_done_valid got=%b exp=0", bus.valid_o); end
    if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL flush_done_ready got=%b exp=1", bus.ready_o); end
    if (bus.result_o !== 32'd42) begin bad++; $display("FAIL flush_done_result got=%h exp=2a", bus.result_o); end

    // Flush in IDLE blocks acceptance
    bus.valid_i = 1'b1; bus.flush_i = 1'b1; bus.funct3_i = MUL; bus.op_a_i = 32'd2; bus.op_b_i = 32'd2;
    @(posedge clk); #1;
    bus.valid_i = 1'b0; bus.flush_i = 1'b0;
    total += 1;
    if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL flush_idle_busy got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat;
    start_op(MUL, 32'h1234, 32'h10);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total += 4;
    if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", bus.valid_o); end
    if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", bus.ready_o); end
    if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy_o); end
    if (bus.result_o !== 32'd0) begin bad++; $display("FAIL midrst_result got=%h exp=0", bus.result_o); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(MUL, 32'h1234, 32'h10, res, lat);
    total += 1;
    if (res !== 32'h12340) begin bad++; $display("FAIL midrst_after got=%h exp=12340", res); end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, exp, res;
    int lat, exp_lat;
    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (i % 3 == 1) b = 32'($urandom_range(1, 20));
      if (i % 5 == 0) b = 32'd0;
      if (i % 7 == 3) begin f = (i % 2 == 0) ? DIV : REM; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      exp = ref_model(f, a, b);
      if (!f[2])                                                   exp_lat = 10;
      else if (b == 0 || ((f == DIV || f == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) exp_lat = 1;
      else                                                         exp_lat = 34;
      do_op(f, a, b, res, lat);
      total += 2;
      if (res !== exp) begin bad++; $display("FAIL rand_result[%0d] f=%0d a=%h b=%h got=%h exp=%h", i, f, a, b, res, exp); end
      if (lat !== exp_lat) begin bad++; $display("FAIL rand_latency[%0d] f=%0d got=%0d exp=%0d", i, f, lat, exp_lat); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_hold();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
